// File: rtl/hack_ram_clr_if.sv
// hack_ram_clr_if -- bus bundle for the clearable single-port word RAM.
//
// Handshake: a command (ld / rd / clr_req with addr, in_data) is sampled on
// every rising clock edge; there is no back-pressure. busy reports a clear
// sweep in progress, and commands seen while busy are not performed. A read
// accepted on edge N is answered by out_valid=1 with out_data for exactly one
// cycle after edge N. ld_drop pulses for one cycle after an edge where a write
// was discarded.
//
// Signals:
//   ld, rd, clr_req  command strobes         (master -> slave)
//   addr, in_data    word address, write data (master -> slave)
//   out_data         registered read data     (slave -> master)
//   out_valid        one-cycle read response  (slave -> master)
//   busy             clear sweep in progress  (slave -> master)
//   ld_drop          one-cycle dropped write  (slave -> master)
//   state_dbg        FSM state, 0=CLEAR 1=IDLE (debug)
//   clr_ptr_dbg      current sweep pointer     (debug)
interface hack_ram_clr_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14
);
    logic              ld;
    logic              rd;
    logic              clr_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              ld_drop;
    logic              state_dbg;
    logic [ADDR_W-1:0] clr_ptr_dbg;

    modport master (
        output ld, rd, clr_req, addr, in_data,
        input  out_data, out_valid, busy, ld_drop, state_dbg, clr_ptr_dbg
    );

    modport slave (
        input  ld, rd, clr_req, addr, in_data,
        output out_data, out_valid, busy, ld_drop, state_dbg, clr_ptr_dbg
    );
endinterface

// File: rtl/hack_ram_clr.sv
// hack_ram_clr -- single-port word RAM (DEPTH = 2**ADDR_W) with a hardware
// clear sweep. After reset, or on clr_req while idle, every word is written to
// zero, one address per cycle; while sweeping, reads are ignored and writes
// are discarded (flagged by ld_drop).
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    hack_ram_clr_if.slave (commands, read response, status, debug)
module hack_ram_clr #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    hack_ram_clr_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              ld_drop_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_fire;
    logic              ld_drop_d;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        mem_we    = 1'b0;
        mem_waddr = bus.addr;
        mem_wdata = bus.in_data;
        rd_fire   = 1'b0;
        ld_drop_d = 1'b0;
        unique case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                ld_drop_d = bus.ld;
                // The last word ends the sweep; the pointer holds rather than
                // wrapping so it never revisits address 0 within a sweep.
                if (clr_ptr_q == '1) begin
                    state_d = IDLE;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            IDLE: begin
                if (bus.clr_req) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                    ld_drop_d = bus.ld;
                end else begin
                    mem_we  = bus.ld;
                    rd_fire = bus.rd;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Storage is deliberately not reset; the post-reset sweep zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Write-first: a simultaneous ld/rd returns the incoming data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ld_drop_q   <= 1'b0;
        end else begin
            out_valid_q <= rd_fire;
            ld_drop_q   <= ld_drop_d;
            if (rd_fire) begin
                out_data_q <= bus.ld ? bus.in_data : mem[bus.addr];
            end
        end
    end

    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.ld_drop     = ld_drop_q;
    assign bus.busy        = (state_q == CLEAR);
    assign bus.state_dbg   = state_q;
    assign bus.clr_ptr_dbg = clr_ptr_q;
endmodule

// File: doc/hack_ram_clr.md
HACK_RAM_CLR -- requirements
Module: hack_ram_clr

Interface
REQ-001 The block SHALL use a single clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter DATA_W, default 16, SHALL set the data word width in bits.
REQ-003 Parameter ADDR_W, default 14, SHALL set the address width; DEPTH = 2**ADDR_W words.
REQ-004 clk  input  1  SHALL be the clock; all state changes occur on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-006 ld  input  1  SHALL be the write enable.
REQ-007 rd  input  1  SHALL be the read request.
REQ-008 clr_req  input  1  SHALL request a full-memory clear sweep.
REQ-009 addr  input  ADDR_W  SHALL be the word address for ld and rd.
REQ-010 in_data  input  DATA_W  SHALL be the write data.
REQ-011 out_data  output  DATA_W  SHALL be the registered read data.
REQ-012 out_valid  output  1  SHALL be a one-cycle pulse marking new out_data.
REQ-013 busy  output  1  SHALL be high while a clear sweep is in progress.
REQ-014 ld_drop  output  1  SHALL be a one-cycle pulse marking a discarded write.

Function
REQ-015 The FSM SHALL have exactly two states, CLEAR and IDLE; busy SHALL be 1 in CLEAR and 0 in IDLE.
REQ-016 In CLEAR, each cycle SHALL write zero to mem[clr_ptr] and increment clr_ptr, starting at 0.
REQ-017 When clr_ptr = DEPTH-1 is written, the FSM SHALL enter IDLE on the next edge; each sweep SHALL last exactly DEPTH cycles.
REQ-018 In IDLE, clr_req=1 SHALL set clr_ptr=0 and enter CLEAR on the next edge.
REQ-019 In CLEAR, clr_req SHALL be ignored: the sweep SHALL NOT restart.
REQ-020 In IDLE with ld=1 and clr_req=0, mem[addr] SHALL take in_data at the rising edge.
REQ-021 In IDLE with rd=1 and clr_req=0, out_data SHALL take mem[addr] and out_valid SHALL be 1 for the following cycle (read latency 1).
REQ-022 If ld=1 and rd=1 in the same cycle, the read SHALL be write-first: out_data SHALL equal in_data.
REQ-023 If rd=0, out_data SHALL hold its last value and out_valid SHALL be 0.
REQ-024 If ld=1 while busy=1, or ld=1 together with clr_req=1 in IDLE, the write SHALL be discarded and ld_drop SHALL pulse for one cycle.
REQ-025 If rd=1 while busy=1, or rd=1 together with clr_req=1 in IDLE, the read SHALL be ignored: out_valid SHALL stay 0 and out_data SHALL hold.
REQ-026 Address arithmetic SHALL be modulo DEPTH; clr_ptr SHALL be ADDR_W bits wide and SHALL NOT wrap within a sweep.

Reset
REQ-027 While rst_n=0: the FSM SHALL be in CLEAR, clr_ptr=0, out_data=0, out_valid=0, ld_drop=0, and busy=1.
REQ-028 Memory contents SHALL NOT be reset directly; they are zeroed only by the sweep that starts on the first rising edge after rst_n rises.
REQ-029 rst_n asserted mid-sweep SHALL abandon the sweep; after release the sweep SHALL restart from address 0 and last the full DEPTH cycles.

Verification (ADDR_W=4, DEPTH=16, DATA_W=16 unless stated)
REQ-030 Release reset -> busy=1 for exactly 16 cycles, then 0; rd addr 5 -> out_data=0x0000 with out_valid=1 on the next cycle.
REQ-031 ld addr 1 data 0x00FF, then rd addr 1 on the next cycle -> out_data=0x00FF, out_valid=1 one cycle after rd; out_data holds 0x00FF while rd=0.
REQ-032 ld=1 and rd=1 in the same cycle at addr 9 with data 0x001F -> out_data=0x001F on the next cycle; a later rd addr 9 -> 0x001F.
REQ-033 ld addr 3 data 0xBEEF during busy -> ld_drop pulses once; after the sweep, rd addr 3 -> 0x0000. clr_req together with ld in IDLE -> ld_drop=1 and busy=1 on the next cycle.
REQ-034 Write 0xAAAA to all 16 addresses, then clr_req -> busy for 16 cycles; all reads return 0. Repeat with rst_n pulsed low at clr_ptr=7 -> outputs reset, the sweep restarts, and busy lasts 16 cycles after release.
REQ-035 With defaults (ADDR_W=14, DATA_W=16): the reset sweep lasts 16384 cycles; ld addr 0x2000 data 0x001F then rd -> 0x001F.
